// File: rtl/mult_seq_if.sv
// Request/response bundle for the sequential HI/LO multiplier.
// start is a one-cycle request that is sampled only while busy=0; each accepted start
// yields exactly one done pulse WIDTH+1 cycles later, and hi/lo stay valid until the next one.
interface mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             state_dbg;

  modport master (
    output start, signed_mode, A, B,
    input  hi, lo, busy, done, state_dbg
  );

  modport slave (
    input  start, signed_mode, A, B,
    output hi, lo, busy, done, state_dbg
  );
endinterface

// File: rtl/mult_seq.sv
// Radix-2 Booth multiplier serving both signed and unsigned multiplies with one datapath.
// One Booth step per cycle over WIDTH+1 extended bits, so latency is a fixed WIDTH+1 cycles.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  mult_seq_if.slave  bus
);

  localparam int XW = WIDTH + 1;
  localparam int AW = 2 * WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [XW-1:0]   a_sh;
  logic [XW-1:0]   b_ext;
  logic [AW-1:0]   acc;
  logic            prev;
  logic [CW-1:0]   step;

  logic [XW:0]     up_wide;
  logic [XW:0]     b_wide;
  logic [XW:0]     sum;
  logic [AW-1:0]   acc_next;

  assign bus.state_dbg = (state == RUN);

  // The sum is carried one bit wider than the upper half so the shift keeps its true sign.
  always_comb begin
    up_wide = {acc[AW-1], acc[AW-1 -: XW]};
    b_wide  = {b_ext[XW-1], b_ext};
    case ({a_sh[0], prev})
      2'b10:   sum = up_wide - b_wide;
      2'b01:   sum = up_wide + b_wide;
      default: sum = up_wide;
    endcase
    acc_next = {sum, acc[XW-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_ext    <= '0;
      acc      <= '0;
      prev     <= 1'b0;
      step     <= '0;
      bus.hi   <= '0;
      bus.lo   <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh     <= {bus.signed_mode & bus.A[WIDTH-1], bus.A};
            b_ext    <= {bus.signed_mode & bus.B[WIDTH-1], bus.B};
            acc      <= '0;
            prev     <= 1'b0;
            step     <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_next;
          prev <= a_sh[0];
          a_sh <= a_sh >> 1;
          step <= step + CW'(1);
          if (step == CW'(WIDTH)) begin
            bus.hi   <= acc_next[2*WIDTH-1:WIDTH];
            bus.lo   <= acc_next[WIDTH-1:0];
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
